altera_tse_tbi_comma_aligner: RTL and testbench

// - Word-alignment stage between the LVDS SERDES receive PMA (10-bit, bit-reversed TBI) and the 1000BASE-X PCS tbi_rx_d input.
// - The LVDS deserializer has no word aligner. This block hunts for the K28.5 comma and pulses a bitslip request until commas land on the word boundary.
// - Once commas are on the boundary, it declares alignment and forwards aligned TBI words to the PCS.
// - Runs entirely in the recovered tbi_rx_clk domain.

---
 rtl/altera_tse_tbi_comma_aligner.sv | 169 ++++++++++++++++
 tb/tb_altera_tse_tbi_comma_aligner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/altera_tse_tbi_comma_aligner.sv
// K28.5 comma word aligner between the LVDS deserializer and the 1000BASE-X PCS receive input.
// Optional macro TSE_ALIGN_LOSS_STATS_EN enables the saturating loss_cnt statistics counter.
module altera_tse_tbi_comma_aligner #(
    parameter int SEARCH_WINDOW = 32,
    parameter int SLIP_WAIT     = 4,
    parameter int LOCK_COUNT    = 3,
    parameter int LOSS_WINDOW   = 256,
    parameter int SLIP_MAX      = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  tbi_rx_d_in,
    input  logic        cda_reset,
    output logic        rx_slip,
    output logic [9:0]  tbi_rx_d_out,
    output logic        aligned,
    output logic [3:0]  slip_pos,
    output logic [15:0] loss_cnt
);

    localparam int WIN_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
    localparam int WCW     = $clog2(WIN_MAX);
    localparam int CCW     = $clog2(LOCK_COUNT + 1);
    localparam int WTW     = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [WCW-1:0] SEARCH_LAST = WCW'(SEARCH_WINDOW - 1);
    localparam logic [WCW-1:0] LOSS_LAST   = WCW'(LOSS_WINDOW - 1);
    localparam logic [WTW-1:0] WAIT_LAST   = WTW'(SLIP_WAIT - 1);
    localparam logic [CCW-1:0] LOCK_VAL    = CCW'(LOCK_COUNT);
    localparam logic [3:0]     SLIP_LAST   = 4'(SLIP_MAX - 1);

    typedef enum logic [2:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_WAIT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [WTW-1:0] wait_cnt;
    logic [CCW-1:0] comma_cnt;

    logic           comma;
    logic [CCW-1:0] comma_inc;
    logic [WCW-1:0] window_last;
    logic [WCW-1:0] word_cnt_inc;
    logic [3:0]     slip_pos_inc;

    // Either running-disparity form of the 7-bit comma at the word boundary.
    assign comma        = (tbi_rx_d_in[6:0] == 7'b1111100) || (tbi_rx_d_in[6:0] == 7'b0000011);
    assign comma_inc    = comma_cnt + 1'b1;
    assign window_last  = (state == ST_LOCKED) ? LOSS_LAST : SEARCH_LAST;
    assign word_cnt_inc = (word_cnt == window_last) ? word_cnt : word_cnt + 1'b1;
    assign slip_pos_inc = (slip_pos == SLIP_LAST) ? 4'd0 : slip_pos + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_SEARCH;
            rx_slip      <= 1'b0;
            tbi_rx_d_out <= '0;
            aligned      <= 1'b0;
            slip_pos     <= '0;
            word_cnt     <= '0;
            wait_cnt     <= '0;
            comma_cnt    <= '0;
        end else begin
            tbi_rx_d_out <= tbi_rx_d_in;
            rx_slip      <= 1'b0;
            if (cda_reset) begin
                state     <= ST_SEARCH;
                aligned   <= 1'b0;
                slip_pos  <= '0;
                word_cnt  <= '0;
                wait_cnt  <= '0;
                comma_cnt <= '0;
            end else begin
                case (state)
                    ST_SEARCH: begin
                        if (comma) begin
                            comma_cnt <= CCW'(1);
                            word_cnt  <= '0;
                            if (LOCK_COUNT == 1) begin
                                state   <= ST_LOCKED;
                                aligned <= 1'b1;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end else if (word_cnt == SEARCH_LAST) begin
                            // Outputs of SLIP are registered on entry so the pulse lines up with the state.
                            state    <= ST_SLIP;
                            rx_slip  <= 1'b1;
                            slip_pos <= slip_pos_inc;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt_inc;
                        end
                    end
                    ST_SLIP: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= ST_SEARCH;
                            word_cnt <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        if (comma) begin
                            comma_cnt <= comma_inc;
                            word_cnt  <= '0;
                            if (comma_inc == LOCK_VAL) begin
                                state   <= ST_LOCKED;
                                aligned <= 1'b1;
                            end
                        end else if (word_cnt == SEARCH_LAST) begin
                            state     <= ST_SLIP;
                            rx_slip   <= 1'b1;
                            slip_pos  <= slip_pos_inc;
                            word_cnt  <= '0;
                            comma_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (comma) begin
                            word_cnt <= '0;
                        end else if (word_cnt == LOSS_LAST) begin
                            state     <= ST_SEARCH;
                            aligned   <= 1'b0;
                            word_cnt  <= '0;
                            comma_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt_inc;
                        end
                    end
                    default: begin
                        state   <= ST_SEARCH;
                        aligned <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TSE_ALIGN_LOSS_STATS_EN
    logic loss_event;

    // A loss is only counted when no restart overrides the LOCKED exit.
    assign loss_event = !cda_reset && (state == ST_LOCKED) && !comma && (word_cnt == LOSS_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != 16'hFFFF)) begin
            loss_cnt <= loss_cnt + 16'd1;
        end
    end
`else
    assign loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_altera_tse_tbi_comma_aligner.sv
// Directed bench for the TBI comma aligner: reset, lock, loss, slip hunting, restart, boundary cases.
module tb_altera_tse_tbi_comma_aligner;

    localparam logic [9:0] K285 = 10'h17C;
    localparam logic [9:0] DATA = 10'h2AA;
`ifdef TSE_ALIGN_LOSS_STATS_EN
    localparam int LOSS_INC = 1;
`else
    localparam int LOSS_INC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cda_reset = 1'b0;
    logic [9:0]  tbi_rx_d_in = '0;
    logic        rx_slip;
    logic [9:0]  tbi_rx_d_out;
    logic        aligned;
    logic [3:0]  slip_pos;
    logic [15:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int off = 0;
    int slips = 0;
    int last_slip = -100000;
    int min_gap = 100000;
    int commas = 0;
    bit slipped = 1'b0;
    logic [79:0] frame;
    logic [9:0]  r;

    altera_tse_tbi_comma_aligner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tbi_rx_d_in  (tbi_rx_d_in),
        .cda_reset    (cda_reset),
        .rx_slip      (rx_slip),
        .tbi_rx_d_out (tbi_rx_d_out),
        .aligned      (aligned),
        .slip_pos     (slip_pos),
        .loss_cnt     (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One word per clock; the line model advances its bit offset on every observed slip pulse.
    task automatic step(input logic [9:0] d);
        tbi_rx_d_in = d;
        @(posedge clk);
        #1;
        n++;
        slipped = rx_slip;
        if (rx_slip) begin
            slips++;
            if (n - last_slip < min_gap) min_gap = n - last_slip;
            last_slip = n;
            off = (off + 1) % 10;
        end
    endtask

    function automatic logic [9:0] stream_word();
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[i] = frame[(10 * n + off + i) % 80];
        return w;
    endfunction

    task automatic sstep();
        logic [9:0] w;
        w = stream_word();
        if (w == K285) commas++;
        step(w);
    endtask

    initial begin
        frame = {{7{DATA}}, K285};

        // Reset with random data on the line
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step(10'($urandom));
        chk("rst_slip", 32'(rx_slip), 0);
        chk("rst_dout", 32'(tbi_rx_d_out), 0);
        chk("rst_aligned", 32'(aligned), 0);
        chk("rst_slip_pos", 32'(slip_pos), 0);
        chk("rst_loss_cnt", 32'(loss_cnt), 0);
        reset_n = 1'b1;
        r = 10'($urandom);
        r[1:0] = 2'b10;
        step(r);
        chk("dpath_1", 32'(tbi_rx_d_out), 32'(r));
        r = 10'($urandom);
        r[1:0] = 2'b10;
        step(r);
        chk("dpath_2", 32'(tbi_rx_d_out), 32'(r));

        // Lock on an aligned stream, comma every 8 words
        off = 0;
        commas = 0;
        slips = 0;
        for (int i = 0; i < 100 && commas < 3; i++) begin
            if (commas == 2 && stream_word() == K285) chk("pre_lock", 32'(aligned), 0);
            sstep();
        end
        chk("lock_aligned", 32'(aligned), 1);
        chk("lock_no_slip", 32'(slips), 0);

        // Loss after 256 words without a comma
        for (int i = 1; i <= 256; i++) begin
            step(DATA);
            if (i == 255) chk("loss_hold", 32'(aligned), 1);
        end
        chk("loss_drop", 32'(aligned), 0);
        chk("loss_cnt_1", 32'(loss_cnt), 32'(LOSS_INC));

        // Stream shifted by 3 bits: seven slips to reach the boundary
        off = 3;
        slips = 0;
        last_slip = -100000;
        min_gap = 100000;
        for (int i = 0; i < 800 && !aligned; i++) sstep();
        chk("mis_aligned", 32'(aligned), 1);
        chk("mis_slips", 32'(slips), 7);
        chk("mis_slip_pos", 32'(slip_pos), 7);
        chk("mis_gap_ge_36", 32'(min_gap >= 36), 1);

        // Lose lock again, then restart while VERIFY holds two commas
        for (int i = 0; i < 256; i++) step(DATA);
        chk("loss_cnt_2", 32'(loss_cnt), 32'(2 * LOSS_INC));
        commas = 0;
        for (int i = 0; i < 100 && commas < 2; i++) sstep();
        chk("ver_slip_pos", 32'(slip_pos), 7);
        chk("ver_not_aligned", 32'(aligned), 0);
        sstep();
        sstep();
        sstep();
        cda_reset = 1'b1;
        sstep();
        cda_reset = 1'b0;
        chk("cda_slip_pos", 32'(slip_pos), 0);
        chk("cda_aligned", 32'(aligned), 0);
        chk("cda_loss_kept", 32'(loss_cnt), 32'(2 * LOSS_INC));
        commas = 0;
        for (int i = 0; i < 100 && commas < 3; i++) begin
            if (commas == 2 && stream_word() == K285) chk("cda_pre_lock", 32'(aligned), 0);
            sstep();
        end
        chk("cda_relock", 32'(aligned), 1);

        // Comma arriving exactly on the last search word wins over the slip
        cda_reset = 1'b1;
        step(DATA);
        cda_reset = 1'b0;
        slips = 0;
        for (int i = 0; i < 31; i++) step(DATA);
        step(K285);
        chk("c31_no_slip_now", 32'(rx_slip), 0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 7; i++) step(DATA);
            step(K285);
        end
        chk("c31_slips", 32'(slips), 0);
        chk("c31_lock", 32'(aligned), 1);

        // Never-aligning stream: slip_pos walks 1..9 then wraps to 0
        cda_reset = 1'b1;
        step(DATA);
        cda_reset = 1'b0;
        slips = 0;
        last_slip = -100000;
        min_gap = 100000;
        chk("nal_pos_start", 32'(slip_pos), 0);
        for (int i = 0; i < 600 && slips < 11; i++) begin
            step(DATA);
            if (slipped) chk($sformatf("nal_pos_after_%0d", slips), 32'(slip_pos), 32'(slips % 10));
        end
        chk("nal_slips", 32'(slips), 11);
        chk("nal_gap_ge_36", 32'(min_gap >= 36), 1);
        chk("nal_aligned", 32'(aligned), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
